d_pipe: RTL
===========

// Module: d_pipe
// PURPOSE
//  Parametrised elastic D-register pipeline: WIDTH-bit data through DEPTH flop stages with valid/ready flow control.
//  Next generation of the single-bit edge-triggered D cell; used wherever SDF-annotated multi-bit retiming is needed.
//  Optional specify block carries CP->Q path delays and setup/hold checks for annotated gate-level sim.
// PARAMETERS
//  WIDTH  8  data bits per stage (>=1)
//  DEPTH  4  number of register stages (>=1); fill latency in cycles
//  CNTW   $clog2(DEPTH+1)  occupancy counter width (derived, not overridden)
// PORTS
//  CP     in   1      clock, rising edge active
//  CDN    in   1      asynchronous active-low reset
//  D      in   WIDTH  input data
//  DV     in   1      input valid
//  DR     out  1      input ready (D accepted when DV&&DR at posedge CP)
//  Q      out  WIDTH  output data (final stage register)
//  QV     out  1      output valid
//  QR     in   1      output ready (Q consumed when QV&&QR at posedge CP)
//  FLUSH  in   1      synchronous clear of all stage valids
//  CNT    out  CNTW   number of valid stages currently held
// BEHAVIOUR
//  - Reset (CDN=0, async): all stage data=0, all valids=0 -> Q=0, QV=0, CNT=0, DR=1 once CDN=1.
//  - Stage k (0=input side, DEPTH-1=output) loads from k-1 when k empty or k advancing downstream.
//  - Stage DEPTH-1 advances when QR=1; stage k advances when stage k+1 loads.
//  - DR = ~v[0] | adv[0]: combinational through the ready chain, no bubble; throughput 1 word/cycle.
//  - Latency: word accepted at edge n appears with QV=1 after edge n+DEPTH-1 when pipe empty and QR=1.
//  - Backpressure QR=0: stages compact forward; DR drops only when all DEPTH stages valid.
//  - Data regs load only on accept (no toggle on hold); Q stable while QV&&!QR.
//  - CNT += (DV&&DR), -= (QV&&QR) each edge; simultaneous accept+consume leaves CNT unchanged.
//  - CNT range 0..DEPTH, never wraps; DV ignored when DR=0 (no overflow).
//  - FLUSH=1: at next edge all valids=0, CNT=0, data regs hold; same-cycle D not accepted (DR=0 while FLUSH).
//  - FLUSH has priority over accept/consume; Q value after flush is don't-care (QV=0).
//  - CDN asserted mid-transfer: all state clears immediately, independent of CP; in-flight data lost.
//  - DEPTH=1: single register, DR = ~QV | QR.
// CONFIGURATION
//  D_PIPE_SPECIFY_EN defined: specify block present:
//   posedge CP => Q rise/fall (1.3:1.5:1.7, 1.1:1.4:1.9); CDN => Q,QV (0.8:1.0:1.2);
//   $setup(D, posedge CP, 1), $hold(posedge CP, D, 0.5), $recovery(posedge CDN, posedge CP, 1).
//  Undefined: no specify block, zero-delay RTL; functional behaviour identical in both builds.
// STRUCTURE
//  - d_pipe_pkg: default delay triples, setup/hold/recovery constants, clog2 helper for CNTW.
//  - Sub-module d_pipe_stage (WIDTH): one data reg + valid flop, ports CP,CDN,in_d,in_v,ld,clr,out_d,out_v;
//    generate-instantiated DEPTH times; ready chain and CNT logic in top level.
// TESTING
//  1 Reset: CDN=0 with DV=1, D=8'hA5 -> Q=0, QV=0, CNT=0; release -> DR=1 next cycle.
//  2 Stream: QR=1, DV=1, D=1,2,3.. each cycle -> Q=1 with QV=1 after 4th edge, then one word/cycle, CNT=4 steady.
//  3 Backpressure: QR=0, push 5 words -> 4 accepted, DR=0 at CNT=4; QR=1 one cycle -> Q=1 out, DR=1, 5th word accepted.
//  4 Simultaneous: full pipe, DV=1 and QR=1 same edge -> CNT stays 4, order preserved, no word dropped/duplicated.
//  5 Flush: CNT=3, FLUSH=1 with DV=1 -> next edge CNT=0, QV=0, D not accepted; next push has latency 4.
//  6 Async reset mid-stream: drop CDN between edges -> QV=0, CNT=0 before next CP edge; with D_PIPE_SPECIFY_EN
//    and SDF, D change 0.5 before CP -> setup violation reported.

Source files
------------

// File: rtl/d_pipe_pkg.sv
// Shared constants for the d_pipe elastic register pipeline: gate-level delay
// triples, timing-check limits and the width helper behind CNTW.
package d_pipe_pkg;

    // CP->Q rise/fall and CDN->Q/QV delays as min:typ:max, in ns
    localparam real CP_Q_RISE_MIN = 1.3;
    localparam real CP_Q_RISE_TYP = 1.5;
    localparam real CP_Q_RISE_MAX = 1.7;
    localparam real CP_Q_FALL_MIN = 1.1;
    localparam real CP_Q_FALL_TYP = 1.4;
    localparam real CP_Q_FALL_MAX = 1.9;
    localparam real CDN_Q_MIN     = 0.8;
    localparam real CDN_Q_TYP     = 1.0;
    localparam real CDN_Q_MAX     = 1.2;

    localparam real SETUP_D    = 1.0;
    localparam real HOLD_D     = 0.5;
    localparam real RECOVERY_R = 1.0;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/d_pipe_stage.sv
// One pipeline stage of d_pipe: a WIDTH-bit data register plus its valid flop.
// Data only loads when a valid word arrives, so held words never toggle.
module d_pipe_stage
    import d_pipe_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CP,
    input  logic             CDN,
    input  logic [WIDTH-1:0] in_d,
    input  logic             in_v,
    input  logic             ld,
    input  logic             clr,
    output logic [WIDTH-1:0] out_d,
    output logic             out_v
);

    always_ff @(posedge CP or negedge CDN) begin
        if (!CDN) begin
            out_d <= '0;
            out_v <= 1'b0;
        end else if (clr) begin
            out_v <= 1'b0;
        end else if (ld) begin
            out_v <= in_v;
            if (in_v) begin
                out_d <= in_d;
            end
        end
    end

endmodule

// File: rtl/d_pipe.sv
// Elastic WIDTH x DEPTH D-register pipeline with valid/ready flow control.
// Define D_PIPE_SPECIFY_EN to add the specify block for SDF-annotated gate-level sim.
module d_pipe
    import d_pipe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNTW  = clog2(DEPTH + 1)
) (
    input  logic             CP,
    input  logic             CDN,
    input  logic [WIDTH-1:0] D,
    input  logic             DV,
    output logic             DR,
    output logic [WIDTH-1:0] Q,
    output logic             QV,
    input  logic             QR,
    input  logic             FLUSH,
    output logic [CNTW-1:0]  CNT
);

    logic [WIDTH-1:0] stage_d [DEPTH];
    logic [DEPTH-1:0] stage_v;
    logic [DEPTH-1:0] ld;
    logic             chain;
    logic             accept;
    logic             consume;

    // A stage loads when it is empty or the stage below it is loading; walking
    // from the output side keeps the ready chain free of combinational feedback.
    always_comb begin
        ld    = '0;
        chain = QR;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            chain = ~stage_v[k] | chain;
            ld[k] = chain;
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_first
            d_pipe_stage #(.WIDTH(WIDTH)) u_stage (
                .CP   (CP),
                .CDN  (CDN),
                .in_d (D),
                .in_v (DV),
                .ld   (ld[k]),
                .clr  (FLUSH),
                .out_d(stage_d[k]),
                .out_v(stage_v[k])
            );
        end else begin : g_next
            d_pipe_stage #(.WIDTH(WIDTH)) u_stage (
                .CP   (CP),
                .CDN  (CDN),
                .in_d (stage_d[k-1]),
                .in_v (stage_v[k-1]),
                .ld   (ld[k]),
                .clr  (FLUSH),
                .out_d(stage_d[k]),
                .out_v(stage_v[k])
            );
        end
    end

    assign DR      = ld[0] & ~FLUSH;
    assign Q       = stage_d[DEPTH-1];
    assign QV      = stage_v[DEPTH-1];
    assign accept  = DV & DR;
    assign consume = QV & QR;

    // Occupancy tracks accepts minus consumes; flush wins over both.
    always_ff @(posedge CP or negedge CDN) begin
        if (!CDN) begin
            CNT <= '0;
        end else if (FLUSH) begin
            CNT <= '0;
        end else if (accept && !consume) begin
            CNT <= CNT + CNTW'(1);
        end else if (!accept && consume) begin
            CNT <= CNT - CNTW'(1);
        end
    end

`ifdef D_PIPE_SPECIFY_EN
    specify
        specparam t_cp_q_rise = CP_Q_RISE_MIN:CP_Q_RISE_TYP:CP_Q_RISE_MAX;
        specparam t_cp_q_fall = CP_Q_FALL_MIN:CP_Q_FALL_TYP:CP_Q_FALL_MAX;
        specparam t_cdn_q     = CDN_Q_MIN:CDN_Q_TYP:CDN_Q_MAX;
        specparam t_setup     = SETUP_D;
        specparam t_hold      = HOLD_D;
        specparam t_recovery  = RECOVERY_R;

        (posedge CP *> Q) = (t_cp_q_rise, t_cp_q_fall);
        (CDN *> Q, QV) = t_cdn_q;
        $setup(D, posedge CP, t_setup);
        $hold(posedge CP, D, t_hold);
        $recovery(posedge CDN, posedge CP, t_recovery);
    endspecify
`endif

endmodule
